multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control sequencer for the multi-cycle MIPS datapath. Takes the registered opcode field (`Instr31_26`) and steps each instruction through fetch, decode, execute, memory and write-back. It drives the enables and mux selects for the PC, memory, instruction register, register file and ALU. It stalls on a memory-ready handshake, traps on unsupported opcodes and counts retired instructions.

## Interface
- `MEM_WAIT_EN` (macro, see Configuration); no Verilog parameters.
- `Clk`  input  1  system clock; all state changes on rising edge.
- `Reset`  input  1  asynchronous, active-high; forces state `S_RST`, clears counter and trap.
- `Opcode`  input  6  from instruction register bits 31:26.
- `Zero`  input  1  ALU zero flag, used in `S_BRANCH`.
- `Mem_Ready`  input  1  memory completion strobe (used only with `MEM_WAIT_EN`).
- `PC_Write`, `PC_Write_Cond`, `IorD`, `Mem_Read`, `Mem_Write`, `Mem_to_Reg`, `Inst_Reg_Write`, `Reg_Dst`, `Reg_Write`, `ALU_Src_A`  output  1 each  datapath controls.
- `ALU_Src_B`  output  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `ALU_Op`  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- `PC_Source`  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `State`  output  4  current state encoding, for debug.
- `Illegal_Op`  output  1  sticky trap flag.
- `Instr_Count`  output  16  retired-instruction counter.

## Operation
- States and encodings: `S_RST`=0, `S_FETCH`=1, `S_DECODE`=2, `S_MEMADR`=3, `S_MEMRD`=4, `S_MEMWB`=5, `S_MEMWR`=6, `S_EXEC`=7, `S_RWB`=8, `S_BRANCH`=9, `S_JUMP`=10, `S_ADDIEX`=11, `S_ADDIWB`=12, `S_TRAP`=15.
- Transitions:
  - `S_RST` → `S_FETCH` unconditionally on the first clock after reset is released.
  - `S_FETCH` → `S_DECODE`.
  - `S_DECODE` branches on opcode: 100011 (lw) and 101011 (sw) → `S_MEMADR`; 000000 (R-type) → `S_EXEC`; 000100 (beq) → `S_BRANCH`; 000010 (j) → `S_JUMP`; 001000 (addi) → `S_ADDIEX`; any other opcode → `S_TRAP`.
  - `S_MEMADR` → `S_MEMRD` for lw, → `S_MEMWR` for sw.
  - `S_MEMRD` → `S_MEMWB`.
  - `S_EXEC` → `S_RWB`.
  - `S_ADDIEX` → `S_ADDIWB`.
  - `S_MEMWB`, `S_MEMWR`, `S_RWB`, `S_ADDIWB`, `S_BRANCH`, `S_JUMP` → `S_FETCH`.
  - `S_TRAP` holds until `Reset`.
- Outputs are Moore decodes of the state. Every output not listed for a state is 0.
  - `S_FETCH`: `Mem_Read`=1, `Inst_Reg_Write`=1, `PC_Write`=1, `ALU_Src_B`=01.
  - `S_DECODE`: `ALU_Src_B`=11.
  - `S_MEMADR`, `S_ADDIEX`: `ALU_Src_A`=1, `ALU_Src_B`=10.
  - `S_MEMRD`: `Mem_Read`=1, `IorD`=1.
  - `S_MEMWR`: `Mem_Write`=1, `IorD`=1.
  - `S_MEMWB`: `Reg_Write`=1, `Mem_to_Reg`=1.
  - `S_EXEC`: `ALU_Src_A`=1, `ALU_Op`=10.
  - `S_RWB`: `Reg_Write`=1, `Reg_Dst`=1.
  - `S_ADDIWB`: `Reg_Write`=1.
  - `S_BRANCH`: `ALU_Src_A`=1, `ALU_Op`=01, `PC_Write_Cond`=1, `PC_Source`=01.
  - `S_JUMP`: `PC_Write`=1, `PC_Source`=10.
  - `S_RST` and `S_TRAP`: all controls 0.
- `Illegal_Op` is set on the edge that enters `S_TRAP` and is cleared only by `Reset`.
- `Instr_Count` increments by 1 on each transition into `S_FETCH` from a terminal state: `S_MEMWB`, `S_MEMWR`, `S_RWB`, `S_ADDIWB`, `S_BRANCH`, `S_JUMP`. It is not incremented on `S_RST`→`S_FETCH`. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset values (asynchronous): `State`=0, `Instr_Count`=0, `Illegal_Op`=0, all controls 0.
- Latency without stalls:
  - R-type and addi: 4 cycles (`S_FETCH` through write-back).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- `Reset` asserted in any state, including mid-memory-access, zeroes all controls within the same cycle, with no clock edge needed.
- `Opcode` is sampled in `S_DECODE` and `S_MEMADR` only. It must be stable from the edge that leaves `S_FETCH`, since the instruction register only updates in `S_FETCH`.

## Configuration
- `MEM_WAIT_EN` defined:
  - `S_FETCH`, `S_MEMRD` and `S_MEMWR` hold while `Mem_Ready`=0.
  - In `S_FETCH`, `Inst_Reg_Write` and `PC_Write` are gated to 1 only when `Mem_Ready`=1.
  - `Mem_Read` and `Mem_Write` stay asserted for the whole wait.
  - If `Mem_Ready`=1 arrives in the same cycle as `Reset`, `Reset` wins.
- `MEM_WAIT_EN` undefined: `Mem_Ready` is ignored, and every memory state lasts exactly 1 cycle.

## Test plan
- Reset, then release: cycle 0 is `State`=0 with all outputs 0; cycle 1 is `State`=1 with `Mem_Read`=1, `Inst_Reg_Write`=1, `PC_Write`=1, `ALU_Src_B`=01.
- `Opcode`=100011 (lw): state sequence is 1, 2, 3, 4, 5, 1; `Instr_Count` goes 0→1; `Mem_to_Reg`=1 and `Reg_Write`=1 in state 5.
- `Opcode`=000100 (beq) with `Zero`=1: state sequence is 1, 2, 9, 1; in state 9, `PC_Write_Cond`=1 and `PC_Source`=01.
- `Opcode`=111111: state sequence is 1, 2, 15; `Illegal_Op`=1 and state 15 holds for 20 cycles; `Instr_Count` is unchanged; `Reset` restores state 0 with `Illegal_Op`=0.
- Preload `Instr_Count`=0xFFFF (via 65535 j instructions or a forced value), then run one j: `Instr_Count`=0x0000.
- With `MEM_WAIT_EN`, sw with `Mem_Ready` held 0 for 3 cycles: `Mem_Write`=1 for 4 cycles in state 6, then state 1. Asserting `Reset` during the wait gives `Mem_Write`=0 immediately.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Purpose : main control sequencer for the multi-cycle MIPS datapath (fetch/decode/exec/mem/wb).
// Latency : R-type/addi 4, lw 5, sw 4, beq/j 3 cycles from S_FETCH; memory states stretch under MEM_WAIT_EN.
// Backpr. : with MEM_WAIT_EN, S_FETCH/S_MEMRD/S_MEMWR hold while Mem_Ready=0; otherwise Mem_Ready is ignored.
//
// Ports:
//   Clk, Reset (async, active-high)       clock and reset
//   Opcode[5:0], Zero, Mem_Ready          instruction opcode, ALU zero flag, memory completion strobe
//   PC_Write .. ALU_Src_A, ALU_Src_B[1:0],
//   ALU_Op[1:0], PC_Source[1:0]           Moore datapath controls
//   State[3:0]                            current state (debug)
//   Illegal_Op                            sticky trap flag, cleared only by Reset
//   Instr_Count[15:0]                     retired-instruction counter, wraps
//
// Build option: define MEM_WAIT_EN to enable the Mem_Ready stall handshake.
// Zero is consumed by the datapath (ANDed with PC_Write_Cond), not by this sequencer.

module multicycle_control_fsm (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        PC_Write,
  output logic        PC_Write_Cond,
  output logic        IorD,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Mem_to_Reg,
  output logic        Inst_Reg_Write,
  output logic        Reg_Dst,
  output logic        Reg_Write,
  output logic        ALU_Src_A,
  output logic [1:0]  ALU_Src_B,
  output logic [1:0]  ALU_Op,
  output logic [1:0]  PC_Source,
  output logic [3:0]  State,
  output logic        Illegal_Op,
  output logic [15:0] Instr_Count
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t      state_q, state_d;
  logic [15:0] instr_cnt_q;
  logic        illegal_q;
  logic        mem_done;
  logic        retire;

`ifdef MEM_WAIT_EN
  assign mem_done = Mem_Ready;
  logic unused_zero;
  assign unused_zero = Zero;
`else
  // Every memory access completes in one cycle; the strobe has no effect.
  assign mem_done = 1'b1;
  logic [1:0] unused_inputs;
  assign unused_inputs = {Zero, Mem_Ready};
`endif

  // An instruction retires when a terminal state hands back to fetch.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
        default:                                            retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_RST;
      instr_cnt_q <= 16'd0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP)
        illegal_q <= 1'b1;
      if (retire)
        instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    PC_Write       = 1'b0;
    PC_Write_Cond  = 1'b0;
    IorD           = 1'b0;
    Mem_Read       = 1'b0;
    Mem_Write      = 1'b0;
    Mem_to_Reg     = 1'b0;
    Inst_Reg_Write = 1'b0;
    Reg_Dst        = 1'b0;
    Reg_Write      = 1'b0;
    ALU_Src_A      = 1'b0;
    ALU_Src_B      = 2'b00;
    ALU_Op         = 2'b00;
    PC_Source      = 2'b00;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        Mem_Read       = 1'b1;
        ALU_Src_B      = 2'b01;
        // IR and PC only capture once the fetched word is actually valid.
        Inst_Reg_Write = mem_done;
        PC_Write       = mem_done;
        if (mem_done)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        ALU_Src_B = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        state_d   = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        Mem_Read = 1'b1;
        IorD     = 1'b1;
        if (mem_done)
          state_d = S_MEMWB;
      end
      S_MEMWR: begin
        Mem_Write = 1'b1;
        IorD      = 1'b1;
        if (mem_done)
          state_d = S_FETCH;
      end
      S_MEMWB: begin
        Reg_Write  = 1'b1;
        Mem_to_Reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        ALU_Src_A = 1'b1;
        ALU_Op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        Reg_Write = 1'b1;
        Reg_Dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        Reg_Write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_Src_A     = 1'b1;
        ALU_Op        = 2'b01;
        PC_Write_Cond = 1'b1;
        PC_Source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PC_Write  = 1'b1;
        PC_Source = 2'b10;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      // Unused encodings recover through the reset state.
      default: state_d = S_RST;
    endcase
  end

  assign State       = state_q;
  assign Illegal_Op  = illegal_q;
  assign Instr_Count = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Purpose : self-checking bench for multicycle_control_fsm with randomized instruction streams.
// Latency : reference model predicts per-instruction state sequences and retire counts.
// Backpr. : Mem_Ready randomized (ignored) in the default build; stall scenarios under MEM_WAIT_EN.

module tb_multicycle_control_fsm;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        Mem_Ready;
  logic        PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, Mem_to_Reg;
  logic        Inst_Reg_Write, Reg_Dst, Reg_Write, ALU_Src_A;
  logic [1:0]  ALU_Src_B, ALU_Op, PC_Source;
  logic [3:0]  State;
  logic        Illegal_Op;
  logic [15:0] Instr_Count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;
  int          exp_seq[$];
  logic [15:0] act_ctrl;

  multicycle_control_fsm dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_to_Reg(Mem_to_Reg),
    .Inst_Reg_Write(Inst_Reg_Write), .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op),
    .PC_Source(PC_Source), .State(State), .Illegal_Op(Illegal_Op),
    .Instr_Count(Instr_Count)
  );

  always #5 Clk = ~Clk;

  assign act_ctrl = {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, Mem_to_Reg,
                     Inst_Reg_Write, Reg_Dst, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source};

  // Control word expected in a given state, straight from the per-state output table.
  function automatic logic [15:0] exp_ctrl(int st, bit rdy);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      1:      begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
      2:      asb = 2'b11;
      3, 11:  begin asa = 1; asb = 2'b10; end
      4:      begin mr = 1; iord = 1; end
      6:      begin mw = 1; iord = 1; end
      5:      begin rw = 1; m2r = 1; end
      7:      begin asa = 1; aop = 2'b10; end
      8:      begin rw = 1; rdst = 1; end
      12:     rw = 1;
      9:      begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      10:     begin pcw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, asa, asb, aop, psrc};
  endfunction

  // States visited after S_FETCH for one instruction, by instruction class.
  function automatic void build_seq(logic [5:0] op);
    exp_seq.delete();
    case (op)
      6'b100011: exp_seq = '{2, 3, 4, 5};
      6'b101011: exp_seq = '{2, 3, 6};
      6'b000000: exp_seq = '{2, 7, 8};
      6'b000100: exp_seq = '{2, 9};
      6'b000010: exp_seq = '{2, 10};
      6'b001000: exp_seq = '{2, 11, 12};
      default:   exp_seq = '{2, 15};
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_cnt = 16'd0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Opcode = 6'd0; Zero = 1'b0; Mem_Ready = 1'b1;
    exp_cnt = 16'd0;
    tick(); tick();
    checks++;
    if (State !== 4'd0 || act_ctrl !== 16'd0 || Instr_Count !== 16'd0 || Illegal_Op !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d ctrl=%h cnt=%h ill=%b, expected 0/0000/0000/0",
               State, act_ctrl, Instr_Count, Illegal_Op);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (State !== 4'd1 || act_ctrl !== exp_ctrl(1, 1'b1) || Instr_Count !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d ctrl=%h cnt=%h, expected 1/%h/0000",
               State, act_ctrl, Instr_Count, exp_ctrl(1, 1'b1));
    end
  endtask

  // Random legal instruction stream; first two are a directed lw and a taken beq.
  task automatic test_random_instrs();
    logic [5:0] legal [6];
    logic [5:0] op;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    for (int n = 0; n < 40; n++) begin
      if (n == 0)      begin op = 6'b100011; Zero = 1'b0; end
      else if (n == 1) begin op = 6'b000100; Zero = 1'b1; end
      else begin
        op = legal[$urandom_range(0, 5)];
        Zero = 1'($urandom);
      end
      Opcode = op;
`ifndef MEM_WAIT_EN
      Mem_Ready = 1'($urandom);
`endif
      build_seq(op);
      foreach (exp_seq[k]) begin
        tick();
        checks++;
        if (State !== 4'(exp_seq[k]) || act_ctrl !== exp_ctrl(exp_seq[k], 1'b1)) begin
          errors++;
          $display("FAIL instr_step op=%b step=%0d: state=%0d ctrl=%h, expected %0d/%h",
                   op, k, State, act_ctrl, exp_seq[k], exp_ctrl(exp_seq[k], 1'b1));
        end
`ifndef MEM_WAIT_EN
        Mem_Ready = 1'($urandom);
`endif
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (State !== 4'd1 || Instr_Count !== exp_cnt || Illegal_Op !== 1'b0) begin
        errors++;
        $display("FAIL instr_retire op=%b: state=%0d cnt=%h ill=%b, expected 1/%h/0",
                 op, State, Instr_Count, Illegal_Op, exp_cnt);
      end
    end
  endtask

  task automatic test_trap();
    logic [5:0] ops [2];
    ops[0] = 6'b111111;
    ops[1] = 6'b000001;
    for (int t = 0; t < 2; t++) begin
      if (t == 1) begin
        // pick a random opcode outside the supported set
        do ops[1] = 6'($urandom_range(0, 63));
        while (ops[1] inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000});
      end
      Opcode = ops[t];
      tick();
      checks++;
      if (State !== 4'd2 || Illegal_Op !== 1'b0) begin
        errors++;
        $display("FAIL trap_decode op=%b: state=%0d ill=%b, expected 2/0", ops[t], State, Illegal_Op);
      end
      for (int c = 0; c < 21; c++) begin
        tick();
        checks++;
        if (State !== 4'd15 || Illegal_Op !== 1'b1 || act_ctrl !== 16'd0 || Instr_Count !== exp_cnt) begin
          errors++;
          $display("FAIL trap_hold op=%b cyc=%0d: state=%0d ill=%b ctrl=%h cnt=%h, expected 15/1/0000/%h",
                   ops[t], c, State, Illegal_Op, act_ctrl, Instr_Count, exp_cnt);
        end
      end
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (State !== 4'd0 || Illegal_Op !== 1'b0 || act_ctrl !== 16'd0 || Instr_Count !== 16'd0) begin
        errors++;
        $display("FAIL trap_reset: state=%0d ill=%b ctrl=%h cnt=%h, expected 0/0/0000/0000",
                 State, Illegal_Op, act_ctrl, Instr_Count);
      end
      do_reset();
      checks++;
      if (State !== 4'd1) begin
        errors++;
        $display("FAIL trap_restart: state=%0d, expected 1", State);
      end
    end
  endtask

  task automatic test_count_wrap();
    force dut.instr_cnt_q = 16'hFFFF;
    #1;
    release dut.instr_cnt_q;
    exp_cnt = 16'hFFFF;
    for (int r = 0; r < 2; r++) begin
      Opcode = 6'b000010;
      tick(); tick(); tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (State !== 4'd1 || Instr_Count !== exp_cnt) begin
        errors++;
        $display("FAIL count_wrap r=%0d: state=%0d cnt=%h, expected 1/%h", r, State, Instr_Count, exp_cnt);
      end
    end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    // Fetch stall: IR/PC writes gated, Mem_Read held.
    Mem_Ready = 1'b0;
    #1;
    checks++;
    if (act_ctrl !== exp_ctrl(1, 1'b0)) begin
      errors++;
      $display("FAIL fetch_stall_ctrl: ctrl=%h, expected %h", act_ctrl, exp_ctrl(1, 1'b0));
    end
    tick();
    checks++;
    if (State !== 4'd1) begin
      errors++;
      $display("FAIL fetch_stall_hold: state=%0d, expected 1", State);
    end
    Mem_Ready = 1'b1;
    Opcode = 6'b101011;
    tick(); tick();
    Mem_Ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) Mem_Ready = 1'b1;
      checks++;
      if (State !== 4'd6 || Mem_Write !== 1'b1) begin
        errors++;
        $display("FAIL sw_wait cyc=%0d: state=%0d mem_write=%b, expected 6/1", c, State, Mem_Write);
      end
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (State !== 4'd1 || Instr_Count !== exp_cnt) begin
      errors++;
      $display("FAIL sw_wait_done: state=%0d cnt=%h, expected 1/%h", State, Instr_Count, exp_cnt);
    end
    // Reset arriving with Mem_Ready mid-wait must win immediately.
    tick(); tick();
    Mem_Ready = 1'b0;
    tick();
    Mem_Ready = 1'b1;
    Reset = 1'b1;
    #1;
    checks++;
    if (Mem_Write !== 1'b0 || State !== 4'd0) begin
      errors++;
      $display("FAIL sw_wait_reset: mem_write=%b state=%0d, expected 0/0", Mem_Write, State);
    end
    tick();
    checks++;
    if (State !== 4'd0 || Instr_Count !== 16'd0) begin
      errors++;
      $display("FAIL sw_reset_hold: state=%0d cnt=%h, expected 0/0000", State, Instr_Count);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_random_instrs();
    test_trap();
    test_count_wrap();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
